// File: rtl/exec_writeback_pkg.sv
// Shared widths, flag bit positions, condition codes and the writeback FIFO entry
// for the execute/writeback slice.
package exec_writeback_pkg;

  localparam int unsigned W_OPR   = 32;
  localparam int unsigned W_FLAGS = 4;
  localparam int unsigned W_RADDR = 5;
  localparam int unsigned W_COND  = 4;
  localparam int unsigned W_COUNT = 2;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 3;

  localparam logic [W_COND-1:0] COND_EQ = 4'd0;
  localparam logic [W_COND-1:0] COND_NE = 4'd1;
  localparam logic [W_COND-1:0] COND_CS = 4'd2;
  localparam logic [W_COND-1:0] COND_CC = 4'd3;
  localparam logic [W_COND-1:0] COND_MI = 4'd4;
  localparam logic [W_COND-1:0] COND_PL = 4'd5;
  localparam logic [W_COND-1:0] COND_VS = 4'd6;
  localparam logic [W_COND-1:0] COND_VC = 4'd7;
  localparam logic [W_COND-1:0] COND_HI = 4'd8;
  localparam logic [W_COND-1:0] COND_LS = 4'd9;
  localparam logic [W_COND-1:0] COND_GE = 4'd10;
  localparam logic [W_COND-1:0] COND_LT = 4'd11;
  localparam logic [W_COND-1:0] COND_GT = 4'd12;
  localparam logic [W_COND-1:0] COND_LE = 4'd13;
  localparam logic [W_COND-1:0] COND_AL = 4'd14;
  localparam logic [W_COND-1:0] COND_NV = 4'd15;

  typedef struct packed {
    logic [W_RADDR-1:0] rd;
    logic [W_OPR-1:0]   result;
  } wb_entry_t;

endpackage

// File: rtl/exec_writeback_cond.sv
// Branch condition evaluation against {V,S,Z,C}; purely combinational so the
// branch unit can reuse it.
module exec_cond_eval
  import exec_writeback_pkg::*;
(
  input  logic [W_FLAGS-1:0] flags,
  input  logic [W_COND-1:0]  cond,
  output logic               cond_true
);

  logic c, z, s, v;

  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign s = flags[FLAG_S];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = s;
      COND_PL: cond_true = ~s;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (s == v);
      COND_LT: cond_true = (s != v);
      COND_GT: cond_true = ~z & (s == v);
      COND_LE: cond_true = z | (s != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_writeback.sv
// Writeback stage: architectural flags register, 2-entry in-order result FIFO
// feeding the register-file write port, and branch condition evaluation.
module exec_writeback
  import exec_writeback_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [W_OPR-1:0]   ex_result_i,
  input  logic [W_FLAGS-1:0] ex_flags_i,
  input  logic [W_RADDR-1:0] ex_rd_i,
  input  logic               ex_we_i,
  input  logic               ex_setf_i,
  output logic [W_FLAGS-1:0] flags_o,
  input  logic [W_COND-1:0]  cond_i,
  output logic               cond_true_o,
  output logic               rf_we_o,
  output logic [W_RADDR-1:0] rf_waddr_o,
  output logic [W_OPR-1:0]   rf_wdata_o,
  input  logic               rf_ready_i
);

  logic [W_COUNT-1:0] count_q, count_nxt;
  wb_entry_t          head_q, head_nxt, tail_q, tail_nxt, new_entry;
  logic [W_FLAGS-1:0] flags_q;
  logic               ready_q, we_q;
  logic               accept, enq, deq;

  assign accept    = ex_valid_i & ready_q;
  assign enq       = accept & ex_we_i;
  assign deq       = we_q & rf_ready_i;
  assign new_entry = '{rd: ex_rd_i, result: ex_result_i};

  // FIFO next state; head is only overwritten on fill or advance so it holds when empty
  always_comb begin
    count_nxt = count_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    case (count_q)
      W_COUNT'(0): begin
        if (enq) begin
          head_nxt  = new_entry;
          count_nxt = W_COUNT'(1);
        end
      end
      W_COUNT'(1): begin
        if (enq && deq) begin
          head_nxt = new_entry;
        end else if (enq) begin
          tail_nxt  = new_entry;
          count_nxt = W_COUNT'(2);
        end else if (deq) begin
          count_nxt = W_COUNT'(0);
        end
      end
      default: begin
        if (deq) begin
          head_nxt  = tail_q;
          count_nxt = W_COUNT'(1);
        end
      end
    endcase
  end

  // Handshake flags are registered from the next occupancy, so nothing input-driven reaches them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
    end else begin
      count_q <= count_nxt;
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      ready_q <= (count_nxt < W_COUNT'(2));
      we_q    <= (count_nxt != W_COUNT'(0));
    end
  end

  // Flags update on accept independent of the FIFO so adc/sbb chains see carry next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (accept && ex_setf_i) begin
      flags_q <= ex_flags_i;
    end
  end

  exec_cond_eval u_cond_eval (
    .flags     (flags_q),
    .cond      (cond_i),
    .cond_true (cond_true_o)
  );

  assign ex_ready_o = ready_q;
  assign rf_we_o    = we_q;
  assign rf_waddr_o = head_q.rd;
  assign rf_wdata_o = head_q.result;
  assign flags_o    = flags_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Self-checking bench for exec_writeback: queue-based reference model under
// random traffic, a condition-code vector table and directed corner sequences.
module tb_exec_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_result_i;
  logic [3:0]  ex_flags_i;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i;
  logic        ex_setf_i;
  logic [3:0]  flags_o;
  logic [3:0]  cond_i;
  logic        cond_true_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_ready_i;

  exec_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid_i  (ex_valid_i),
    .ex_ready_o  (ex_ready_o),
    .ex_result_i (ex_result_i),
    .ex_flags_i  (ex_flags_i),
    .ex_rd_i     (ex_rd_i),
    .ex_we_i     (ex_we_i),
    .ex_setf_i   (ex_setf_i),
    .flags_o     (flags_o),
    .cond_i      (cond_i),
    .cond_true_o (cond_true_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_ready_i  (rf_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [3:0] fl;
    logic [3:0] cnd;
    logic       exp;
  } cvec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t m_q[$];
  ent_t m_last;
  logic [3:0] m_flags;
  logic [4:0] wr_log[$];
  cvec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cd);
    bit c, z, n, v, ge;
    c = f[0]; z = f[1]; n = f[2]; v = f[3];
    ge = (n ^ v) == 1'b0;
    case (cd)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !(c && !z);
      10: return ge;
      11: return !ge;
      12: return !z && ge;
      13: return !(!z && ge);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_flags = '0;
  endtask

  // One clock: drive at negedge, compare against the model, advance the model,
  // then park inputs idle just after the edge so hand checks see post-edge state.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [3:0] fl,
                       input logic [4:0] rd, input logic we, input logic setf,
                       input logic [3:0] cnd, input logic rdy);
    ent_t hd;
    bit acc, ret;
    @(negedge clk);
    ex_valid_i = v; ex_result_i = res; ex_flags_i = fl; ex_rd_i = rd;
    ex_we_i = we; ex_setf_i = setf; cond_i = cnd; rf_ready_i = rdy;
    #1;
    hd = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("ex_ready", 32'(ex_ready_o), 32'(m_q.size() < 2));
    chk("rf_we", 32'(rf_we_o), 32'(m_q.size() != 0));
    chk("rf_waddr", 32'(rf_waddr_o), 32'(hd.rd));
    chk("rf_wdata", rf_wdata_o, hd.d);
    chk("flags", 32'(flags_o), 32'(m_flags));
    chk("cond_true", 32'(cond_true_o), 32'(ref_cond(m_flags, cnd)));
    if (rf_we_o && rdy) wr_log.push_back(rf_waddr_o);
    if (rst) begin
      model_reset();
    end else begin
      acc = v && (m_q.size() < 2);
      ret = (m_q.size() != 0) && rdy;
      if (ret) m_last = m_q.pop_front();
      if (acc && we) m_q.push_back('{rd: rd, d: res});
      if (acc && setf) m_flags = fl;
    end
    @(posedge clk);
    #1;
    ex_valid_i = 1'b0;
    rf_ready_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd14, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 4'd10, 1'b0};
    tbl[1]  = '{4'b0100, 4'd11, 1'b1};
    tbl[2]  = '{4'b0010, 4'd13, 1'b1};
    tbl[3]  = '{4'b0010, 4'd12, 1'b0};
    tbl[4]  = '{4'b0010, 4'd0,  1'b1};
    tbl[5]  = '{4'b0001, 4'd8,  1'b1};
    tbl[6]  = '{4'b0011, 4'd8,  1'b0};
    tbl[7]  = '{4'b0011, 4'd9,  1'b1};
    tbl[8]  = '{4'b1000, 4'd6,  1'b1};
    tbl[9]  = '{4'b1000, 4'd7,  1'b0};
    tbl[10] = '{4'b1100, 4'd10, 1'b1};
    tbl[11] = '{4'b0000, 4'd3,  1'b1};

    rst = 1'b1;
    ex_valid_i = 0; ex_result_i = '0; ex_flags_i = '0; ex_rd_i = '0;
    ex_we_i = 0; ex_setf_i = 0; cond_i = 4'd14; rf_ready_i = 0;
    model_reset();
    #1;
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_rf_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_flags", 32'(flags_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // add 0xFFFFFFFF+1 -> result 0, Z and C set, writes r3
    cycle(1, 32'h0, 4'b0011, 5'd3, 1, 1, 4'd0, 0);
    chk("t1_flags", 32'(flags_o), 32'b0011);
    chk("t1_rf_we", 32'(rf_we_o), 32'd1);
    chk("t1_waddr", 32'(rf_waddr_o), 32'd3);
    chk("t1_wdata", rf_wdata_o, 32'd0);
    drain();

    // write port stalled: two accepts then backpressure, then in-order drain
    wr_log.delete();
    cycle(1, 32'h11, 4'b0, 5'd1, 1, 0, 4'd14, 0);
    cycle(1, 32'h22, 4'b0, 5'd2, 1, 0, 4'd14, 0);
    chk("t2_full_ready", 32'(ex_ready_o), 32'd0);
    cycle(1, 32'h33, 4'b0, 5'd3, 1, 0, 4'd14, 0);
    chk("t2_stall_waddr", 32'(rf_waddr_o), 32'd1);
    cycle(1, 32'h33, 4'b0, 5'd3, 1, 0, 4'd14, 1);
    cycle(1, 32'h33, 4'b0, 5'd3, 1, 0, 4'd14, 1);
    drain();
    chk("t2_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("t2_wr0", 32'(wr_log[0]), 32'd1);
      chk("t2_wr1", 32'(wr_log[1]), 32'd2);
      chk("t2_wr2", 32'(wr_log[2]), 32'd3);
    end

    // compare: flags only, no register write
    cycle(1, 32'h5, 4'b0100, 5'd6, 0, 1, 4'd4, 1);
    chk("t3_flags", 32'(flags_o), 32'b0100);
    chk("t3_rf_we", 32'(rf_we_o), 32'd0);

    // occupancy 1 with simultaneous enqueue and retire
    cycle(1, 32'hAAAA_0007, 4'b0, 5'd7, 1, 0, 4'd14, 0);
    cycle(1, 32'hBBBB_0009, 4'b0, 5'd9, 1, 0, 4'd14, 1);
    chk("t4_rf_we", 32'(rf_we_o), 32'd1);
    chk("t4_waddr", 32'(rf_waddr_o), 32'd9);
    chk("t4_wdata", rf_wdata_o, 32'hBBBB_0009);
    chk("t4_ready", 32'(ex_ready_o), 32'd1);
    drain();
    chk("t4_empty_hold", 32'(rf_waddr_o), 32'd9);

    // condition-code vectors, flags loaded through a compare
    foreach (tbl[i]) begin
      cycle(1, '0, tbl[i].fl, '0, 0, 1, tbl[i].cnd, 1);
      chk("t5_cond_vec", 32'(cond_true_o), 32'(tbl[i].exp));
    end
    for (int f = 0; f < 16; f++) begin
      cycle(1, '0, 4'(f), '0, 0, 1, 4'd14, 1);
      chk("t5_al", 32'(cond_true_o), 32'd1);
      cond_i = 4'd15;
      #1;
      chk("t5_nv", 32'(cond_true_o), 32'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 5'($urandom),
            $urandom_range(0, 4) != 0, 1'($urandom), 4'($urandom),
            $urandom_range(0, 2) != 0);
    end
    drain();

    // async reset with two entries held
    cycle(1, 32'h1234, 4'b1111, 5'd12, 1, 1, 4'd14, 0);
    cycle(1, 32'h5678, 4'b1010, 5'd13, 1, 1, 4'd14, 0);
    chk("t6_pre_full", 32'(ex_ready_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rf_we", 32'(rf_we_o), 32'd0);
    chk("t6_ready", 32'(ex_ready_o), 32'd1);
    chk("t6_flags", 32'(flags_o), 32'd0);
    model_reset();
    wr_log.delete();
    cycle(0, '0, '0, '0, 0, 0, 4'd14, 1);
    rst = 1'b0;
    drain();
    chk("t6_no_write", 32'(wr_log.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
